banked_pingpong_mem: RTL
========================

BANKED_PINGPONG_MEM -- requirements
Module: banked_pingpong_mem

Interface
REQ-001 SHALL have parameter NBANK, default 4, number of byte-lane banks per buffer.
REQ-002 SHALL have parameter DW, default 8, data width per bank.
REQ-003 SHALL have parameter AW, default 10, address width; depth per bank is 2^AW.
REQ-004 SHALL have port clk  input  1  sole clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port wr_addr  input  AW  write address into the write buffer.
REQ-007 SHALL have port wr_data  input  NBANK*DW  write data; bank i is slice [i*DW +: DW].
REQ-008 SHALL have port wr_be  input  NBANK  per-bank write enable.
REQ-009 SHALL have port rd_req  input  1  read request.
REQ-010 SHALL have port rd_addr  input  AW  read address into the read buffer.
REQ-011 SHALL have port rd_data  output  NBANK*DW  read data; bank i is slice [i*DW +: DW].
REQ-012 SHALL have port rd_valid  output  1  rd_data is valid this cycle.
REQ-013 SHALL have port swap_req  input  1  request to exchange the write and read buffers.
REQ-014 SHALL have port swap_done  output  1  one-cycle pulse when the swap completes.
REQ-015 SHALL have port clr_req  input  1  request to zero the entire write buffer.
REQ-016 SHALL have port clr_done  output  1  one-cycle pulse when the clear completes.
REQ-017 SHALL have port busy  output  1  high when state is not RUN.
REQ-018 SHALL have port wr_sel  output  1  index of the current write buffer; the read buffer is !wr_sel.

Function
REQ-019 SHALL contain 2*NBANK synchronous single-clock RAMs, each 2^AW x DW, forming buffer 0 and buffer 1; RAM contents are not reset.
REQ-020 SHALL implement an FSM with states RUN, DRAIN and CLEAR, one-hot or binary encoded.
REQ-021 SHALL, in RUN, write bank i of buffer wr_sel at wr_addr with slice i of wr_data for every bit i set in wr_be; other banks are untouched.
REQ-022 SHALL ignore wr_be and rd_req whenever busy=1.
REQ-023 SHALL, for rd_req=1 accepted at cycle t, present all NBANK banks of buffer !wr_sel at rd_addr on rd_data with rd_valid=1 at cycle t+2 (RAM register plus output register).
REQ-024 SHALL hold rd_data unchanged while rd_valid=0.
REQ-025 SHALL accept back-to-back reads every cycle, giving a throughput of 1 read per cycle.
REQ-026 SHALL, on swap_req=1 in RUN, enter DRAIN on the next cycle; a write or read presented in the same cycle as swap_req is still accepted.
REQ-027 SHALL, in DRAIN, wait until both read-pipeline stages are empty, then toggle wr_sel, pulse swap_done for 1 cycle (the cycle wr_sel shows the new value) and return to RUN.
REQ-028 SHALL, on clr_req=1 in RUN with swap_req=0, enter CLEAR with the sweep counter at 0.
REQ-029 SHALL give swap_req priority over clr_req when both are high in the same RUN cycle; the clr_req is dropped.
REQ-030 SHALL, in CLEAR, write 0 to every bank of buffer wr_sel at address = counter and increment the counter by 1 each cycle.
REQ-031 SHALL, when the counter equals 2^AW-1, perform that final write, pulse clr_done for 1 cycle, return to RUN and reset the counter to 0; CLEAR lasts exactly 2^AW cycles.
REQ-032 SHALL let in-flight reads complete normally during DRAIN and CLEAR, because the read buffer is never written.
REQ-033 SHALL ignore swap_req and clr_req when not in RUN; requests are not queued.
REQ-034 SHALL make a write and a read in the same cycle to the same address non-conflicting, since they always target different buffers.

Reset
REQ-035 SHALL, on reset=0 at a clock edge, set state=RUN, wr_sel=0, busy=0, rd_valid=0, rd_data=0, swap_done=0, clr_done=0, counter=0, and flush the read pipeline.
REQ-036 SHALL, on reset during CLEAR or DRAIN, abort the operation with no done pulse; partially cleared RAM contents are left as is.

Verification (NBANK=4, DW=8, AW=10)
REQ-037 Bench SHALL cover: write 0xDDCCBBAA to addr 5 with wr_be=4'hF, then swap, then rd_req addr 5 at cycle t -> rd_valid=1 and rd_data=0xDDCCBBAA at t+2.
REQ-038 Bench SHALL cover: write addr 7 with wr_be=4'b0101 and data 0x44332211 over a prior 0 -> after swap, read returns 0x00330011.
REQ-039 Bench SHALL cover: rd_req on 3 consecutive cycles with swap_req in the third -> all 3 rd_valid are returned, then swap_done pulses with wr_sel toggled, and busy=1 throughout DRAIN.
REQ-040 Bench SHALL cover: clr_req -> busy stays high for exactly 1024 cycles, clr_done pulses once, and a subsequent swap plus read of addr 0 and addr 1023 returns 0.
REQ-041 Bench SHALL cover: swap_req and clr_req high in the same cycle -> only the swap is performed and clr_done never pulses.
REQ-042 Bench SHALL cover: reset=0 at cycle 500 of CLEAR -> next cycle busy=0, wr_sel=0, rd_valid=0, and no clr_done pulse.

Source files
------------

// File: rtl/banked_pingpong_mem_if.sv
// Bus bundle for banked_pingpong_mem: write port, pipelined read port,
// buffer swap/clear control and status.
interface banked_pingpong_mem_if #(
    parameter int NBANK = 4,
    parameter int DW    = 8,
    parameter int AW    = 10
);
    logic [AW-1:0]       wr_addr;
    logic [NBANK*DW-1:0] wr_data;
    logic [NBANK-1:0]    wr_be;
    logic                rd_req;
    logic [AW-1:0]       rd_addr;
    logic [NBANK*DW-1:0] rd_data;
    logic                rd_valid;
    logic                swap_req;
    logic                swap_done;
    logic                clr_req;
    logic                clr_done;
    logic                busy;
    logic                wr_sel;

    modport master (
        output wr_addr, wr_data, wr_be, rd_req, rd_addr, swap_req, clr_req,
        input  rd_data, rd_valid, swap_done, clr_done, busy, wr_sel
    );

    modport slave (
        input  wr_addr, wr_data, wr_be, rd_req, rd_addr, swap_req, clr_req,
        output rd_data, rd_valid, swap_done, clr_done, busy, wr_sel
    );
endinterface

// File: rtl/banked_pingpong_mem.sv
// Two byte-lane banked buffers used ping-pong: one takes writes while the other
// serves two-cycle-latency reads; swap drains the read pipe, clear sweeps zeros.
module banked_pingpong_mem #(
    parameter int NBANK = 4,
    parameter int DW    = 8,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    banked_pingpong_mem_if.slave bus
);
    localparam int              DEPTH    = 1 << AW;
    localparam int              WW       = NBANK * DW;
    localparam logic [AW-1:0]   CNT_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]   CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   CNT_LAST = {AW{1'b1}};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                wr_sel_r, wr_sel_nxt_s;
    logic [AW-1:0]       cnt_r, cnt_nxt_s;
    logic                busy_r;
    logic                swap_done_r, swap_done_nxt_s;
    logic                clr_done_r, clr_done_nxt_s;
    logic                rd_accept_s;
    logic                s1_valid_r, s1_sel_r;
    logic                rd_valid_r;
    logic [WW-1:0]       rd_data_r;
    logic [AW-1:0]       ram_waddr_s;
    logic [WW-1:0]       ram_wdata_s;
    logic [NBANK-1:0]    ram_be_s;
    logic [1:0][NBANK-1:0] ram_we_s;
    logic [1:0][WW-1:0]  ram_q_s;

    // Next-state logic: swap wins over clear, requests outside RUN are dropped
    always_comb begin
        state_nxt_s     = state_r;
        wr_sel_nxt_s    = wr_sel_r;
        cnt_nxt_s       = cnt_r;
        swap_done_nxt_s = 1'b0;
        clr_done_nxt_s  = 1'b0;
        case (state_r)
            RUN: begin
                if (bus.swap_req) begin
                    state_nxt_s = DRAIN;
                end else if (bus.clr_req) begin
                    state_nxt_s = CLEAR;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (!s1_valid_r && !rd_valid_r) begin
                    state_nxt_s     = RUN;
                    wr_sel_nxt_s    = ~wr_sel_r;
                    swap_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            CLEAR: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s    = RUN;
                    cnt_nxt_s      = CNT_ZERO;
                    clr_done_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, buffer select, sweep counter and status registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= RUN;
            wr_sel_r    <= 1'b0;
            cnt_r       <= CNT_ZERO;
            busy_r      <= 1'b0;
            swap_done_r <= 1'b0;
            clr_done_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wr_sel_r    <= wr_sel_nxt_s;
            cnt_r       <= cnt_nxt_s;
            busy_r      <= (state_nxt_s != RUN);
            swap_done_r <= swap_done_nxt_s;
            clr_done_r  <= clr_done_nxt_s;
        end
    end

    // RAM port steering: user traffic in RUN, zero sweep in CLEAR, nothing otherwise
    always_comb begin
        rd_accept_s = 1'b0;
        ram_waddr_s = bus.wr_addr;
        ram_wdata_s = bus.wr_data;
        ram_be_s    = {NBANK{1'b0}};
        case (state_r)
            RUN: begin
                rd_accept_s = bus.rd_req;
                ram_be_s    = bus.wr_be;
            end
            CLEAR: begin
                ram_waddr_s = cnt_r;
                ram_wdata_s = {WW{1'b0}};
                ram_be_s    = {NBANK{1'b1}};
            end
            default: begin
                rd_accept_s = 1'b0;
                ram_be_s    = {NBANK{1'b0}};
            end
        endcase
        // Writes only ever land in the current write buffer, never during reset
        ram_we_s[0] = (reset && !wr_sel_r) ? ram_be_s : {NBANK{1'b0}};
        ram_we_s[1] = (reset &&  wr_sel_r) ? ram_be_s : {NBANK{1'b0}};
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        for (genvar i = 0; i < NBANK; i++) begin : g_bank
            logic [DW-1:0] ram_r [DEPTH];
            logic [DW-1:0] q_r;

            // Single-port-write, registered-read bank RAM (contents not reset)
            always_ff @(posedge clk) begin
                if (ram_we_s[b][i]) begin
                    ram_r[ram_waddr_s] <= ram_wdata_s[i*DW +: DW];
                end
                if (rd_accept_s) begin
                    q_r <= ram_r[bus.rd_addr];
                end
            end

            assign ram_q_s[b][i*DW +: DW] = q_r;
        end
    end

    // Read pipeline: RAM stage tracks which buffer was read, output stage holds data
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_sel_r   <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WW{1'b0}};
        end else begin
            s1_valid_r <= rd_accept_s;
            if (rd_accept_s) begin
                s1_sel_r <= ~wr_sel_r;
            end
            rd_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                rd_data_r <= ram_q_s[s1_sel_r];
            end
        end
    end

    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.swap_done = swap_done_r;
    assign bus.clr_done  = clr_done_r;
    assign bus.busy      = busy_r;
    assign bus.wr_sel    = wr_sel_r;
endmodule
